// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results (port A, priority) with a
// buffered long-latency unit (port B, valid/ready FIFO) onto the register-file
// write port. Also exports a pending-write scoreboard and a starvation stall.
module writeback_arbiter #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  input  logic [ADDR_WIDTH-1:0]      a_rd,
  input  logic [WIDTH-1:0]           a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [ADDR_WIDTH-1:0]      b_rd,
  input  logic [WIDTH-1:0]           b_data,
  output logic                       RegWrite,
  output logic [ADDR_WIDTH-1:0]      Rd,
  output logic [WIDTH-1:0]           WriteData,
  output logic [(2**ADDR_WIDTH)-1:0] pending,
  output logic                       stall_req,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] rd_mem_q   [DEPTH];
  logic [WIDTH-1:0]      data_mem_q [DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [StarveW-1:0]    starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [WIDTH-1:0]      data_q, data_d;

  logic a_eff;
  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);
  // Ready is a function of occupancy only, so it never loops back through b_valid.
  assign b_ready    = rst && (count_q < CntW'(DEPTH));
  // Writes to x0 are architecturally dead; drop them at the door.
  assign a_eff      = a_valid && (a_rd != '0);
  assign push       = b_valid && b_ready && (b_rd != '0);
  assign pop        = !a_eff && !fifo_empty;

  assign RegWrite   = we_q;
  assign Rd         = rd_q;
  assign WriteData  = data_q;
  assign stall_req  = stall_q;
  assign fifo_count = count_q;

  // Next-state for FIFO pointers, occupancy, output register and starvation tracking.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    we_d     = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (a_eff) begin
      we_d   = 1'b1;
      rd_d   = a_rd;
      data_d = a_data;
    end else if (pop) begin
      we_d   = 1'b1;
      rd_d   = rd_mem_q[rd_ptr_q];
      data_d = data_mem_q[rd_ptr_q];
    end

    // Count cycles B loses to A; any B progress or an empty queue resets it.
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (a_eff && (starve_q != StarveW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end

    // Stall follows a saturated counter by one cycle and drops once B drains.
    stall_d = (starve_q == StarveW'(STARVE_LIMIT)) && !pop;
  end

  // Pending scoreboard: every occupied FIFO slot plus the write in flight; x0 never pending.
  always_comb begin
    logic [PtrW-1:0] idx;
    pending = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if (CntW'(i) < count_q) pending[rd_mem_q[idx]] = 1'b1;
    end
    if (we_q) pending[rd_q] = 1'b1;
    pending[0] = 1'b0;
  end

  // Control and output registers; reset empties the queue at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= b_rd;
      data_mem_q[wr_ptr_q] <= b_data;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a cycle model predicts each
// register-file write and queues it; the DUT output is compared a cycle later.
module tb_writeback_arbiter;

  localparam int unsigned Width   = 32;
  localparam int unsigned AddrW   = 5;
  localparam int unsigned Depth   = 4;
  localparam int unsigned Limit   = 2;
  localparam int unsigned NumRegs = 2 ** AddrW;

  logic                  clk;
  logic                  rst;
  logic                  a_valid;
  logic [AddrW-1:0]      a_rd;
  logic [Width-1:0]      a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [AddrW-1:0]      b_rd;
  logic [Width-1:0]      b_data;
  logic                  RegWrite;
  logic [AddrW-1:0]      Rd;
  logic [Width-1:0]      WriteData;
  logic [NumRegs-1:0]    pending;
  logic                  stall_req;
  logic [$clog2(Depth):0] fifo_count;

  writeback_arbiter #(
    .WIDTH       (Width),
    .ADDR_WIDTH  (AddrW),
    .DEPTH       (Depth),
    .STARVE_LIMIT(Limit)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .RegWrite  (RegWrite),
    .Rd        (Rd),
    .WriteData (WriteData),
    .pending   (pending),
    .stall_req (stall_req),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AddrW-1:0] rd;
    logic [Width-1:0] data;
  } ent_t;

  typedef struct {
    logic             we;
    logic [AddrW-1:0] rd;
    logic [Width-1:0] data;
    logic             stall;
  } out_t;

  ent_t mq[$];
  out_t exp_q[$];

  logic             m_we;
  logic [AddrW-1:0] m_rd;
  logic [Width-1:0] m_data;
  int unsigned      m_cnt;
  logic             m_stall;
  bit               saw_stall;
  bit               acc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_we    = 1'b0;
    m_rd    = '0;
    m_data  = '0;
    m_cnt   = 0;
    m_stall = 1'b0;
  endtask

  // One clock of stimulus: check pre-edge state, predict the write, advance, compare.
  task automatic step(output bit accepted);
    logic [NumRegs-1:0] exp_pend;
    logic               hz;
    bit                 a_eff;
    bit                 pop_m;
    bit                 nstall;
    ent_t               e;
    out_t               o;
    #1;
    exp_pend = '0;
    foreach (mq[k]) exp_pend[mq[k].rd] = 1'b1;
    if (m_we) exp_pend[m_rd] = 1'b1;
    exp_pend[0] = 1'b0;
    check("pending", 64'(pending), 64'(exp_pend));
    check("fifo_count", 64'(fifo_count), 64'(mq.size()));
    check("b_ready", 64'(b_ready), 64'(mq.size() < Depth));
    if (a_valid && a_rd != '0) begin
      hz = pending[a_rd];
      check("a_hazard", 64'(hz), 64'(0));
    end

    a_eff    = a_valid && (a_rd != '0);
    pop_m    = !a_eff && (mq.size() != 0);
    accepted = b_valid && (mq.size() < Depth);

    nstall = (m_cnt == Limit) && !pop_m;
    if (pop_m || mq.size() == 0) m_cnt = 0;
    else if (a_eff && m_cnt < Limit) m_cnt++;

    if (a_eff) begin
      m_we = 1'b1; m_rd = a_rd; m_data = a_data;
    end else if (pop_m) begin
      e = mq.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (accepted && b_rd != '0) mq.push_back('{rd: b_rd, data: b_data});
    m_stall = nstall;
    exp_q.push_back('{we: m_we, rd: m_rd, data: m_data, stall: m_stall});

    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check("RegWrite", 64'(RegWrite), 64'(o.we));
    check("Rd", 64'(Rd), 64'(o.rd));
    check("WriteData", 64'(WriteData), 64'(o.data));
    check("stall_req", 64'(stall_req), 64'(o.stall));
    if (stall_req) saw_stall = 1'b1;
  endtask

  task automatic drive(input bit av, input int ard, input logic [Width-1:0] ad,
                       input bit bv, input int brd, input logic [Width-1:0] bd);
    a_valid = av;  a_rd = AddrW'(ard); a_data = ad;
    b_valid = bv;  b_rd = AddrW'(brd); b_data = bd;
    step(acc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    rst = 1'b0;
    a_valid = 0; a_rd = '0; a_data = '0;
    b_valid = 0; b_rd = '0; b_data = '0;
    saw_stall = 1'b0;
    model_reset();
    #12;
    check("rst_RegWrite", 64'(RegWrite), 64'(0));
    check("rst_Rd", 64'(Rd), 64'(0));
    check("rst_WriteData", 64'(WriteData), 64'(0));
    check("rst_b_ready", 64'(b_ready), 64'(0));
    check("rst_pending", 64'(pending), 64'(0));
    check("rst_stall", 64'(stall_req), 64'(0));
    check("rst_count", 64'(fifo_count), 64'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // ALU write lands one cycle later, then RegWrite drops
    drive(1, 5, 32'hDEADBEEF, 0, 0, '0);
    idle(2);

    // B entry waits behind three A cycles; A rd alternates to respect hazards
    drive(1, 3, 32'h0000_0301, 1, 7, 32'h11);
    drive(1, 4, 32'h0000_0402, 0, 0, '0);
    drive(1, 3, 32'h0000_0303, 0, 0, '0);
    idle(4);

    // Starvation: A held while five B results are offered into a 4-deep FIFO
    b_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_valid = 1'b1; a_rd = AddrW'(2 + (i % 2)); a_data = 32'hA000 + 32'(i);
      if (!b_valid) begin b_rd = '0; b_data = '0; end
      else begin b_rd = AddrW'(11 + mq.size() + 0); b_data = 32'hB000 + 32'(b_rd); end
      step(acc);
      if (acc) b_valid = (mq.size() < 5) && (i < 4);
    end
    check("starve_full", 64'(b_ready), 64'(0));
    check("stall_seen", 64'(saw_stall), 64'(1));
    // Upstream obeys the stall; queued B results drain and the fifth gets in
    a_valid = 1'b0;
    b_valid = 1'b1; b_rd = AddrW'(15); b_data = 32'hB00F;
    for (int t = 0; t < 20 && b_valid; t++) begin
      step(acc);
      if (acc) b_valid = 1'b0;
    end
    check("b5_accepted", 64'(b_valid), 64'(0));
    b_valid = 1'b0;
    idle(7);

    // a_rd==0 is ignored in favour of the queued B entry; b_rd==0 is dropped
    drive(0, 0, '0, 1, 9, 32'h99);
    drive(1, 0, 32'hBAD0, 0, 0, '0);
    drive(0, 0, '0, 1, 0, 32'hBAD1);
    idle(2);

    // Back-to-back B stream with pointer wrap
    for (int i = 1; i <= 10; i++) drive(0, 0, '0, 1, i, 32'hC00 + 32'(i));
    idle(3);

    // Asynchronous reset with three entries queued
    drive(1, 4, 32'h1, 1, 20, 32'h20);
    drive(1, 5, 32'h2, 1, 21, 32'h21);
    drive(1, 4, 32'h3, 1, 22, 32'h22);
    a_valid = 0; a_rd = '0; b_valid = 0; b_rd = '0;
    check("pre_rst_count", 64'(fifo_count), 64'(3));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_RegWrite", 64'(RegWrite), 64'(0));
    check("mid_rst_pending", 64'(pending), 64'(0));
    check("mid_rst_count", 64'(fifo_count), 64'(0));
    check("mid_rst_b_ready", 64'(b_ready), 64'(0));
    model_reset();
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
